// File: rtl/sub_arbiter.sv
// Two-requester round-robin front end sharing one combinational subtractor.
// Each operation walks IDLE -> EXEC -> RESP, so at most one is in flight.

module sub #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             overflow,
  output logic             borrow
);
  logic [WIDTH:0] diff;

  // The extra top bit of the zero-extended difference is the unsigned borrow.
  assign diff     = {1'b0, A} - {1'b0, B};
  assign Result   = diff[WIDTH-1:0];
  assign borrow   = diff[WIDTH];
  assign overflow = (A[WIDTH-1] != B[WIDTH-1]) && (Result[WIDTH-1] != A[WIDTH-1]);
endmodule

module sub_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_Result,
  output logic             rsp_overflow,
  output logic             rsp_borrow,
  output logic             busy,
  output logic [15:0]      op_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] sub_result;
  logic             sub_overflow, sub_borrow;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept = (state == IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  sub #(.WIDTH(WIDTH)) u_sub (
    .A        (a_q),
    .B        (b_q),
    .Result   (sub_result),
    .overflow (sub_overflow),
    .borrow   (sub_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_Result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_borrow   <= 1'b0;
      op_count     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= grant ? req1_A : req0_A;
            b_q   <= grant ? req1_B : req0_B;
            id_q  <= grant;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_Result   <= sub_result;
          rsp_overflow <= sub_overflow;
          rsp_borrow   <= sub_borrow;
          rsp_id       <= id_q;
          state        <= RESP;
        end
        RESP: begin
          // Fairness pointer only moves once the response is consumed.
          if (rsp_ready) begin
            last_grant <= rsp_id;
            op_count   <= op_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_arbiter.sv
// Self-checking bench for sub_arbiter: directed vectors plus a randomized
// run compared against a transaction-level model of arbitration and subtraction.

module tb_sub_arbiter;
  localparam int W = 64;
  localparam logic signed [W:0] SMAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SMIN = {2'b11, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id;
  logic         rsp_overflow, rsp_borrow, busy;
  logic [W-1:0] rsp_Result;
  logic [15:0]  op_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_count = 16'd0;
  bit          model_last = 1'b1;

  always #5 clk = ~clk;

  sub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_Result(rsp_Result), .rsp_overflow(rsp_overflow), .rsp_borrow(rsp_borrow),
    .busy(busy), .op_count(op_count)
  );

  // Handshake exclusivity holds every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ((req0_ready && req1_ready) || (rsp_valid && (req0_ready || req1_ready))) begin
        miscompares++;
        $display("FAIL handshake_excl: r0=%0b r1=%0b rsp_valid=%0b, need at most one high",
                 req0_ready, req1_ready, rsp_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: true signed difference in W+1 bits; overflow when it leaves W-bit range.
  function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ov, output logic bw);
    logic signed [W:0] d;
    d  = $signed({a[W-1], a}) - $signed({b[W-1], b});
    r  = a - b;
    bw = (a < b);
    ov = (d > SMAX) || (d < SMIN);
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return {1'b1, {(W-1){1'b0}}};
      2: return {1'b0, {(W-1){1'b1}}};
      3: return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drive_req(input bit id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!id) begin req0_valid = v; req0_A = a; req0_B = b; end
    else     begin req1_valid = v; req1_A = a; req1_B = b; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_req(0, 0, '0, '0);
    drive_req(1, 0, '0, '0);
    rsp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count  = 16'd0;
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_req(0, 0, '0, '0);
    drive_req(1, 0, '0, '0);
    @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_overflow, rsp_borrow} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%0b rsp_valid=%0b r0=%0b r1=%0b id=%0b ov=%0b bw=%0b, need all 0",
               busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_overflow, rsp_borrow);
    end
    vectors++;
    if (rsp_Result !== '0 || op_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_data: result=%h op_count=%0d, need 0 and 0", rsp_Result, op_count);
    end
    drive_req(0, 1, 64'h1, 64'h1);
    drive_req(1, 1, 64'h2, 64'h1);
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tie: r0=%0b r1=%0b, need r0=1 r1=0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    drive_req(0, 0, '0, '0);
    drive_req(1, 0, '0, '0);
    rst_n = 1'b1;
    exp_count  = 16'd0;
    model_last = 1'b1;
  endtask

  task automatic run_op(input string name, input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input logic [W-1:0] er, input logic eov, input logic ebw);
    bit got;
    @(posedge clk); #1;
    drive_req(id, 1, a, b);
    rsp_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1; break; end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_accept: ready never rose for id %0d", name, id);
      drive_req(id, 0, '0, '0);
      return;
    end
    @(posedge clk); #1;
    drive_req(id, 0, '0, '0);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_exec: rsp_valid=%0b busy=%0b, need 0 and 1", name, rsp_valid, busy);
    end
    @(posedge clk); #1;
    for (int k = 0; k <= stall; k++) begin
      rsp_ready = (k == stall);
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_Result !== er || rsp_overflow !== eov ||
          rsp_borrow !== ebw || op_count !== exp_count) begin
        miscompares++;
        $display("FAIL %s_rsp[%0d]: valid=%0b id=%0b res=%h ov=%0b bw=%0b cnt=%0d, need 1 %0b %h %0b %0b %0d",
                 name, k, rsp_valid, rsp_id, rsp_Result, rsp_overflow, rsp_borrow, op_count,
                 id, er, eov, ebw, exp_count);
      end
      @(posedge clk); #1;
    end
    rsp_ready  = 1'b0;
    exp_count  = exp_count + 16'd1;
    model_last = id;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== exp_count) begin
      miscompares++;
      $display("FAIL %s_done: rsp_valid=%0b busy=%0b cnt=%0d, need 0 0 %0d",
               name, rsp_valid, busy, op_count, exp_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_op("basic", 0, 64'h5, 64'h3, 0, 64'h2, 1'b0, 1'b0);
    vectors++;
    if (op_count !== 16'd1) begin
      miscompares++;
      $display("FAIL basic_count: op_count=%0d, need 1", op_count);
    end
    run_op("neg", 1, 64'hA, 64'h14, 0, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 1'b1);
    run_op("ovf", 0, 64'h8000_0000_0000_0000, 64'h1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    run_op("stall", 0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5,
           64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    bit exp_ids[3] = '{0, 1, 0};
    logic [W-1:0] a[2], b[2], er;
    logic eov, ebw;
    int got;
    do_reset();
    a[0] = 64'h100; b[0] = 64'h1;
    a[1] = 64'h3;   b[1] = 64'h7;
    @(posedge clk); #1;
    drive_req(0, 1, a[0], b[0]);
    drive_req(1, 1, a[1], b[1]);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ref_sub(a[exp_ids[got]], b[exp_ids[got]], er, eov, ebw);
        vectors++;
        if (rsp_id !== exp_ids[got] || rsp_Result !== er || rsp_overflow !== eov || rsp_borrow !== ebw) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: id=%0b res=%h, need id=%0b res=%h", got, rsp_id, rsp_Result,
                   exp_ids[got], er);
        end
        got++;
      end
      @(posedge clk); #1;
      if (got == 3) begin
        drive_req(0, 0, '0, '0);
        drive_req(1, 0, '0, '0);
      end
    end
    drive_req(0, 0, '0, '0);
    drive_req(1, 0, '0, '0);
    rsp_ready = 1'b0;
    vectors++;
    if (got != 3) begin
      miscompares++;
      $display("FAIL rr_count: %0d responses seen, need 3", got);
    end
    exp_count  = 16'd3;
    model_last = 1'b0;
    @(negedge clk);
    vectors++;
    if (op_count !== exp_count || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_final: cnt=%0d busy=%0b, need %0d and 0", op_count, busy, exp_count);
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    @(posedge clk); #1;
    drive_req(0, 1, 64'h40, 64'h2);
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rexec_accept: r0=%0b, need 1", req0_ready);
    end
    @(posedge clk); #1;
    drive_req(0, 0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 16'd0) begin
      miscompares++;
      $display("FAIL rexec_reset: busy=%0b rsp_valid=%0b cnt=%0d, need 0 0 0", busy, rsp_valid, op_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count  = 16'd0;
    model_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
        miscompares++;
        $display("FAIL rexec_quiet[%0d]: rsp_valid=%0b cnt=%0d, need 0 and 0", c, rsp_valid, op_count);
      end
    end
    run_op("rexec_next", 1, 64'h9, 64'h4, 0, 64'h5, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int ncyc);
    bit infl, acc0, acc1, exp_g, pid;
    int age;
    logic [1:0] exp_rdy;
    logic [W-1:0] pa, pb, er;
    logic eov, ebw;
    do_reset();
    infl = 0; acc0 = 0; acc1 = 0; age = 0; pid = 0;
    pa = '0; pb = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (acc0 || !req0_valid) drive_req(0, ($urandom_range(0, 3) != 0), rnd(), rnd());
      if (acc1 || !req1_valid) drive_req(1, ($urandom_range(0, 3) != 0), rnd(), rnd());
      acc0 = 0; acc1 = 0;
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (infl) age++;
      exp_g   = (req0_valid && req1_valid) ? !model_last : req1_valid;
      exp_rdy = (!infl && (req0_valid || req1_valid)) ? (exp_g ? 2'b10 : 2'b01) : 2'b00;
      vectors++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        miscompares++;
        $display("FAIL rnd_grant[%0d]: r1r0=%b, need %b", c, {req1_ready, req0_ready}, exp_rdy);
      end
      vectors++;
      if (rsp_valid !== (infl && age >= 2) || op_count !== exp_count) begin
        miscompares++;
        $display("FAIL rnd_state[%0d]: rsp_valid=%0b cnt=%0d, need %0b %0d", c, rsp_valid, op_count,
                 (infl && age >= 2), exp_count);
      end
      if (infl && age >= 2) begin
        ref_sub(pa, pb, er, eov, ebw);
        vectors++;
        if (rsp_id !== pid || rsp_Result !== er || rsp_overflow !== eov || rsp_borrow !== ebw) begin
          miscompares++;
          $display("FAIL rnd_rsp[%0d]: id=%0b res=%h ov=%0b bw=%0b, need %0b %h %0b %0b", c,
                   rsp_id, rsp_Result, rsp_overflow, rsp_borrow, pid, er, eov, ebw);
        end
        if (rsp_ready) begin
          infl       = 0;
          model_last = pid;
          exp_count  = exp_count + 16'd1;
        end
      end else if (!infl && (req0_valid || req1_valid)) begin
        infl = 1; age = 0; pid = exp_g;
        pa = exp_g ? req1_A : req0_A;
        pb = exp_g ? req1_B : req0_B;
        acc0 = !exp_g; acc1 = exp_g;
      end
    end
    drive_req(0, 0, '0, '0);
    drive_req(1, 0, '0, '0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_round_robin();
    test_reset_exec();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
